// File: rtl/fft_iter_addr_gen_if.sv
// Strobes from the FFT control unit and the address outputs toward the data RAM / twiddle ROM.
interface fft_iter_addr_gen_if #(
    parameter int LayWL  = 3,
    parameter int AddrWL = 5,
    parameter int TwWL   = 4
);
    logic              EN;
    logic              ADDR_RST;
    logic              ADDR_EN;
    logic              LAY_EN;
    logic [AddrWL-1:0] ADDR_A_R;
    logic [AddrWL-1:0] ADDR_B_R;
    logic [TwWL-1:0]   TW_ADDR;
    logic [AddrWL-1:0] ADDR_A_WR;
    logic [AddrWL-1:0] ADDR_B_WR;
    logic              WR_VALID;
    logic [LayWL-1:0]  LAY_NUM;
    logic              LAST_BUT;

    modport master (
        output EN, ADDR_RST, ADDR_EN, LAY_EN,
        input  ADDR_A_R, ADDR_B_R, TW_ADDR, ADDR_A_WR, ADDR_B_WR, WR_VALID, LAY_NUM, LAST_BUT
    );

    modport slave (
        input  EN, ADDR_RST, ADDR_EN, LAY_EN,
        output ADDR_A_R, ADDR_B_R, TW_ADDR, ADDR_A_WR, ADDR_B_WR, WR_VALID, LAY_NUM, LAST_BUT
    );
endinterface

// File: rtl/fft_iter_addr_gen.sv
// In-place radix-2 DIT address generator: read/twiddle addresses from butterfly/layer
// counters, plus write-back addresses delayed by the butterfly pipeline depth.
module fft_iter_addr_gen #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4,
    parameter int AddrWL      = 5,
    parameter int TwWL        = 4,
    parameter int WR_DELAY    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    fft_iter_addr_gen_if.slave bus
);
    logic [ButtWL-1:0] b;
    logic [LayWL-1:0]  l;

    logic [WR_DELAY-1:0]             vld_pipe;
    logic [WR_DELAY-1:0][AddrWL-1:0] a_pipe;
    logic [WR_DELAY-1:0][AddrWL-1:0] b_pipe;

    logic [AddrWL-1:0] b_ext, half, grp, pos, addr_a, addr_b;
    logic [LayWL-1:0]  tw_shift;

    always_comb begin
        b_ext    = AddrWL'(b);
        half     = AddrWL'(1) << l;
        grp      = b_ext >> l;
        pos      = b_ext & (half - AddrWL'(1));
        addr_a   = (grp << (l + LayWL'(1))) + pos;
        addr_b   = addr_a + half;
        tw_shift = LayWL'(LAYERS - 1) - l;
    end

    always_ff @(posedge CLK) begin
        if (RST || bus.ADDR_RST) begin
            b        <= '0;
            l        <= '0;
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else if (bus.EN) begin
            if (bus.ADDR_EN)
                b <= (b == ButtWL'(BUTTERFLYES - 1)) ? '0 : b + ButtWL'(1);
            // Layer counter saturates; the butterfly wrap never bumps it.
            if (bus.LAY_EN && l != LayWL'(LAYERS - 1))
                l <= l + LayWL'(1);
            vld_pipe[0] <= bus.ADDR_EN;
            a_pipe[0]   <= addr_a;
            b_pipe[0]   <= addr_b;
            for (int i = 1; i < WR_DELAY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
        end
    end

    assign bus.ADDR_A_R  = addr_a;
    assign bus.ADDR_B_R  = addr_b;
    assign bus.TW_ADDR   = pos[TwWL-1:0] << tw_shift;
    assign bus.ADDR_A_WR = a_pipe[WR_DELAY-1];
    assign bus.ADDR_B_WR = b_pipe[WR_DELAY-1];
    assign bus.WR_VALID  = vld_pipe[WR_DELAY-1];
    assign bus.LAY_NUM   = l;
    assign bus.LAST_BUT  = (l == LayWL'(LAYERS - 1)) && (b == ButtWL'(BUTTERFLYES - 1));
endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Directed test of fft_iter_addr_gen with hand-computed expected addresses.
module tb_fft_iter_addr_gen;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    fft_iter_addr_gen_if #(.LayWL(3), .AddrWL(5), .TwWL(4)) bus ();

    fft_iter_addr_gen #(
        .LAYERS(5), .BUTTERFLYES(16), .LayWL(3), .ButtWL(4),
        .AddrWL(5), .TwWL(4), .WR_DELAY(2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input int a, input int b, input int tw);
        chk({tag, " A"}, 32'(bus.ADDR_A_R), a);
        chk({tag, " B"}, 32'(bus.ADDR_B_R), b);
        chk({tag, " TW"}, 32'(bus.TW_ADDR), tw);
    endtask

    task automatic pulses(input int n, input logic addr_en, input logic lay_en);
        bus.ADDR_EN = addr_en;
        bus.LAY_EN  = lay_en;
        for (int i = 0; i < n; i++) tick();
        bus.ADDR_EN = 1'b0;
        bus.LAY_EN  = 1'b0;
    endtask

    task automatic addr_rst();
        bus.ADDR_RST = 1'b1;
        tick();
        bus.ADDR_RST = 1'b0;
    endtask

    initial begin
        logic [31:0] seen;
        int dup;
        n_checks = 0;
        n_fail   = 0;
        RST = 1'b1;
        bus.EN = 1'b1;
        bus.ADDR_RST = 1'b0;
        bus.ADDR_EN  = 1'b0;
        bus.LAY_EN   = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        tick();

        // 1: reset state
        chk_rd("rst", 0, 1, 0);
        chk("rst WR_VALID", 32'(bus.WR_VALID), 0);
        chk("rst A_WR", 32'(bus.ADDR_A_WR), 0);
        chk("rst B_WR", 32'(bus.ADDR_B_WR), 0);
        chk("rst LAY_NUM", 32'(bus.LAY_NUM), 0);
        chk("rst LAST_BUT", 32'(bus.LAST_BUT), 0);

        // 2: l=0,b=3 then l=1,b=3
        pulses(3, 1'b1, 1'b0);
        chk_rd("l0b3", 6, 7, 0);
        pulses(1, 1'b0, 1'b1);
        chk_rd("l1b3", 5, 7, 8);
        chk("l1b3 LAY_NUM", 32'(bus.LAY_NUM), 1);

        // 3: l=2,b=5 ; l=4,b=5 ; saturation
        addr_rst();
        pulses(2, 1'b0, 1'b1);
        pulses(5, 1'b1, 1'b0);
        chk_rd("l2b5", 9, 13, 4);
        chk("l2b5 LAY_NUM", 32'(bus.LAY_NUM), 2);
        pulses(2, 1'b0, 1'b1);
        chk_rd("l4b5", 5, 21, 5);
        pulses(1, 1'b0, 1'b1);
        chk("sat LAY_NUM", 32'(bus.LAY_NUM), 4);
        chk_rd("sat l4b5", 5, 21, 5);

        // 4: write-back delay, then with an EN=0 stall
        addr_rst();
        tick();
        chk("dly idle WR_VALID", 32'(bus.WR_VALID), 0);
        pulses(1, 1'b1, 1'b0);
        chk("dly +1 WR_VALID", 32'(bus.WR_VALID), 0);
        tick();
        chk("dly +2 WR_VALID", 32'(bus.WR_VALID), 1);
        chk("dly +2 A_WR", 32'(bus.ADDR_A_WR), 0);
        chk("dly +2 B_WR", 32'(bus.ADDR_B_WR), 1);
        tick();
        chk("dly +3 WR_VALID", 32'(bus.WR_VALID), 0);
        tick();
        pulses(1, 1'b1, 1'b0);
        bus.EN = 1'b0;
        bus.ADDR_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall WR_VALID", 32'(bus.WR_VALID), 0);
        end
        chk_rd("stall hold l0b2", 4, 5, 0);
        bus.ADDR_EN = 1'b0;
        bus.EN = 1'b1;
        tick();
        chk("stall end WR_VALID", 32'(bus.WR_VALID), 1);
        chk("stall end A_WR", 32'(bus.ADDR_A_WR), 2);
        chk("stall end B_WR", 32'(bus.ADDR_B_WR), 3);
        tick();
        chk("stall after WR_VALID", 32'(bus.WR_VALID), 0);

        // wrap alone leaves the layer untouched
        addr_rst();
        pulses(16, 1'b1, 1'b0);
        chk("wrap LAY_NUM", 32'(bus.LAY_NUM), 0);
        chk_rd("wrap l0b0", 0, 1, 0);

        // 5: full 80-butterfly run, LAY_EN alongside every wrapping ADDR_EN
        addr_rst();
        for (int ly = 0; ly < 5; ly++) begin
            seen = '0;
            dup  = 0;
            for (int bf = 0; bf < 16; bf++) begin
                if (seen[bus.ADDR_A_R]) dup++;
                seen[bus.ADDR_A_R] = 1'b1;
                if (seen[bus.ADDR_B_R]) dup++;
                seen[bus.ADDR_B_R] = 1'b1;
                chk("full B-A", 32'(bus.ADDR_B_R) - 32'(bus.ADDR_A_R), 32'(1) << ly);
                chk("full LAST_BUT", 32'(bus.LAST_BUT), (ly == 4 && bf == 15) ? 1 : 0);
                chk("full LAY_NUM", 32'(bus.LAY_NUM), ly);
                bus.ADDR_EN = 1'b1;
                bus.LAY_EN  = (bf == 15);
                tick();
            end
            bus.ADDR_EN = 1'b0;
            bus.LAY_EN  = 1'b0;
            chk("full coverage", seen, 32'hFFFF_FFFF);
            chk("full duplicates", 32'(dup), 0);
        end
        chk_rd("full end l4b0", 0, 16, 0);
        chk("full end LAY_NUM", 32'(bus.LAY_NUM), 4);
        chk("full end LAST_BUT", 32'(bus.LAST_BUT), 0);

        // 6: ADDR_RST with two entries in flight; also while EN=0
        addr_rst();
        pulses(2, 1'b1, 1'b0);
        chk("flight WR_VALID", 32'(bus.WR_VALID), 1);
        bus.EN = 1'b0;
        addr_rst();
        bus.EN = 1'b1;
        chk_rd("flush", 0, 1, 0);
        chk("flush LAY_NUM", 32'(bus.LAY_NUM), 0);
        for (int i = 0; i < 3; i++) begin
            chk("flush WR_VALID", 32'(bus.WR_VALID), 0);
            tick();
        end
        chk_rd("restart", 0, 1, 0);
        pulses(1, 1'b1, 1'b0);
        tick();
        chk("restart WR_VALID", 32'(bus.WR_VALID), 1);
        chk("restart A_WR", 32'(bus.ADDR_A_WR), 0);
        chk("restart B_WR", 32'(bus.ADDR_B_WR), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
